// File: rtl/chroma_nl_transform.sv
// Luma-dependent nonlinear chroma transform for one chroma channel.
// Pixels with luma outside the knee window are rescaled; all other pixels bypass in one cycle.
module chroma_nl_transform #(
  parameter int DW        = 8,
  parameter int FRAC      = 8,
  parameter int K_L       = 125,
  parameter int K_H       = 188,
  parameter int Y_MIN     = 16,
  parameter int Y_MAX     = 235,
  parameter int MEAN_BASE = 154,
  parameter int MEAN_LO_D = -10,
  parameter int MEAN_HI_D = 22,
  parameter int WC        = 38,
  parameter int WL        = 20,
  parameter int WH        = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] in_y,
  input  logic [DW-1:0] in_c,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_c,
  output logic          out_xform,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int NW = DW + FRAC;
  localparam int CW = $clog2(NW + 1);
  localparam int PW = DW + NW + 3;

  localparam logic [DW-1:0] YMIN_V = DW'(Y_MIN);
  localparam logic [DW-1:0] YMAX_V = DW'(Y_MAX);
  localparam logic [DW-1:0] KL_V   = DW'(K_L);
  localparam logic [DW-1:0] KH_V   = DW'(K_H);

  localparam logic [NW-1:0]        DIVIDEND = NW'(WC) << FRAC;
  localparam logic signed [PW-1:0] HALF_P   = PW'(1) <<< (FRAC - 1);
  localparam logic signed [PW-1:0] BASE_P   = PW'(MEAN_BASE);
  localparam logic signed [PW-1:0] CMAX_P   = PW'((2 ** DW) - 1);

  typedef enum logic [2:0] {IDLE, CALC, DIV, MUL, OUT} state_t;

  state_t                state_q, state_d;
  logic [DW-1:0]         yc_q, yc_d;
  logic [DW-1:0]         c_q, c_d;
  logic signed [DW+1:0]  cbar_q, cbar_d;
  logic [NW-1:0]         w_q, w_d;
  logic [NW-1:0]         rem_q, rem_d;
  logic [NW-1:0]         num_q, num_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         oc_q, oc_d;
  logic                  ox_q, ox_d;

  logic [DW-1:0]         yc_in;
  logic                  bypass_in;
  logic                  accept;
  logic signed [31:0]    yc_s;
  logic [NW:0]           trial;
  logic signed [DW+1:0]  d_s;
  logic signed [PW-1:0]  p_s, rnd_s, r_s, v_s;
  logic [DW-1:0]         mul_c;

  always_comb begin
    if (in_y < YMIN_V)      yc_in = YMIN_V;
    else if (in_y > YMAX_V) yc_in = YMAX_V;
    else                    yc_in = in_y;
    bypass_in = !en || ((yc_in >= KL_V) && (yc_in <= KH_V));
  end

  assign yc_s  = $signed(32'(yc_q));
  assign trial = {rem_q, num_q[NW-1]};

  // Rounded product d*Q, rebased on MEAN_BASE and saturated to the sample range.
  always_comb begin
    d_s   = $signed({2'b00, c_q}) - cbar_q;
    p_s   = PW'(d_s) * $signed({{(PW-NW){1'b0}}, num_q});
    rnd_s = p_s + HALF_P;
    r_s   = rnd_s >>> FRAC;
    v_s   = r_s + BASE_P;
    if (v_s[PW-1])        mul_c = '0;
    else if (v_s > CMAX_P) mul_c = '1;
    else                   mul_c = v_s[DW-1:0];
  end

  always_comb begin
    state_d  = state_q;
    yc_d     = yc_q;
    c_d      = c_q;
    cbar_d   = cbar_q;
    w_d      = w_q;
    rem_d    = rem_q;
    num_d    = num_q;
    cnt_d    = cnt_q;
    oc_d     = oc_q;
    ox_d     = ox_q;
    in_ready = (state_q == IDLE) || ((state_q == OUT) && out_ready);
    accept   = in_valid && in_ready;

    case (state_q)
      CALC: begin
        if (yc_q < KL_V) begin
          cbar_d = (DW+2)'(MEAN_BASE + (MEAN_LO_D * (K_L - yc_s)) / (K_L - Y_MIN));
          w_d    = NW'(WL + ((yc_s - Y_MIN) * (WC - WL)) / (K_L - Y_MIN));
        end else begin
          cbar_d = (DW+2)'(MEAN_BASE + (MEAN_HI_D * (yc_s - K_H)) / (Y_MAX - K_H));
          w_d    = NW'(WH + ((Y_MAX - yc_s) * (WC - WH)) / (Y_MAX - K_H));
        end
        num_d   = DIVIDEND;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = DIV;
      end
      DIV: begin
        // num_q shifts the dividend out and the quotient in; a zero divisor yields all ones.
        if (trial >= {1'b0, w_q}) begin
          rem_d = NW'(trial - {1'b0, w_q});
          num_d = {num_q[NW-2:0], 1'b1};
        end else begin
          rem_d = trial[NW-1:0];
          num_d = {num_q[NW-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NW - 1)) state_d = MUL;
      end
      MUL: begin
        oc_d    = mul_c;
        ox_d    = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: ;
    endcase

    if (accept) begin
      yc_d = yc_in;
      c_d  = in_c;
      if (bypass_in) begin
        oc_d    = in_c;
        ox_d    = 1'b0;
        state_d = OUT;
      end else begin
        state_d = CALC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      yc_q    <= '0;
      c_q     <= '0;
      cbar_q  <= '0;
      w_q     <= '0;
      rem_q   <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      oc_q    <= '0;
      ox_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      yc_q    <= yc_d;
      c_q     <= c_d;
      cbar_q  <= cbar_d;
      w_q     <= w_d;
      rem_q   <= rem_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      oc_q    <= oc_d;
      ox_q    <= ox_d;
    end
  end

  assign out_valid = (state_q == OUT);
  assign out_c     = oc_q;
  assign out_xform = ox_q;

endmodule

// File: tb/tb_chroma_nl_transform.sv
// Self-checking bench for chroma_nl_transform (Cr defaults) against an arithmetic reference model.
module tb_chroma_nl_transform;

  localparam int DW        = 8;
  localparam int FRAC      = 8;
  localparam int K_L       = 125;
  localparam int K_H       = 188;
  localparam int Y_MIN     = 16;
  localparam int Y_MAX     = 235;
  localparam int MEAN_BASE = 154;
  localparam int MEAN_LO_D = -10;
  localparam int MEAN_HI_D = 22;
  localparam int WC        = 38;
  localparam int WL        = 20;
  localparam int WH        = 10;
  localparam int XLAT      = DW + FRAC + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [DW-1:0] in_y;
  logic [DW-1:0] in_c;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_c;
  logic          out_xform;
  logic          out_valid;
  logic          out_ready;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  chroma_nl_transform #(
    .DW(DW), .FRAC(FRAC), .K_L(K_L), .K_H(K_H), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
    .MEAN_BASE(MEAN_BASE), .MEAN_LO_D(MEAN_LO_D), .MEAN_HI_D(MEAN_HI_D),
    .WC(WC), .WL(WL), .WH(WH)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .in_y(in_y), .in_c(in_c),
    .in_valid(in_valid), .in_ready(in_ready), .out_c(out_c),
    .out_xform(out_xform), .out_valid(out_valid), .out_ready(out_ready)
  );

  // Reference: straight from the transform equations with integer arithmetic.
  function automatic int ref_c(input int y, input int c, input bit e, output bit xf);
    int yc, cbar, w, q, num, r, v;
    yc = (y < Y_MIN) ? Y_MIN : ((y > Y_MAX) ? Y_MAX : y);
    if (!e || (yc >= K_L && yc <= K_H)) begin
      xf = 1'b0;
      return c;
    end
    xf = 1'b1;
    if (yc < K_L) begin
      cbar = MEAN_BASE + (MEAN_LO_D * (K_L - yc)) / (K_L - Y_MIN);
      w    = WL + ((yc - Y_MIN) * (WC - WL)) / (K_L - Y_MIN);
    end else begin
      cbar = MEAN_BASE + (MEAN_HI_D * (yc - K_H)) / (Y_MAX - K_H);
      w    = WH + ((Y_MAX - yc) * (WC - WH)) / (Y_MAX - K_H);
    end
    q   = (w == 0) ? (1 << (DW + FRAC)) - 1 : (WC * (1 << FRAC)) / w;
    num = (c - cbar) * q + (1 << (FRAC - 1));
    r   = num / (1 << FRAC);
    if (num < 0 && (num % (1 << FRAC)) != 0) r = r - 1;
    v = r + MEAN_BASE;
    if (v < 0) v = 0;
    if (v > (1 << DW) - 1) v = (1 << DW) - 1;
    return v;
  endfunction

  // Drives one pixel, waits (bounded) for its result and consumes it.
  task automatic do_pixel(input int y, input int c, input bit e,
                          output int oc, output bit ox, output int lat, output bit to);
    int guard;
    @(negedge clk);
    in_y = DW'(y); in_c = DW'(c); en = e; in_valid = 1'b1; out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    to = !out_valid;
    oc = int'(out_c);
    ox = out_xform;
    if (!to) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_c !== '0) $display("FAIL reset_out_c: got %0d want 0", out_c); else n_pass++;
    n_total++; if (out_xform !== 1'b0) $display("FAIL reset_out_xform: got %b want 0", out_xform); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_vectors();
    int tv [7][6] = '{
      '{100, 150, 1, 152, 1, 19},
      '{200, 180, 1, 181, 1, 19},
      '{235, 255, 1, 255, 1, 19},
      '{ 16,   0, 1,   0, 1, 19},
      '{  5,   0, 1,   0, 1, 19},
      '{150,  77, 1,  77, 0,  1},
      '{100, 150, 0, 150, 0,  1}
    };
    int oc, lat;
    bit ox, to;
    for (int i = 0; i < 7; i++) begin
      do_pixel(tv[i][0], tv[i][1], tv[i][2] != 0, oc, ox, lat, to);
      n_total++;
      if (to || oc != tv[i][3]) $display("FAIL vec%0d_out_c: got %0d want %0d (timeout=%0d)", i, oc, tv[i][3], to);
      else n_pass++;
      n_total++;
      if (ox != (tv[i][4] != 0)) $display("FAIL vec%0d_xform: got %0d want %0d", i, ox, tv[i][4]);
      else n_pass++;
      n_total++;
      if (lat != tv[i][5]) $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, tv[i][5]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int edge_y [8] = '{124, 125, 188, 189, 0, 255, Y_MIN, Y_MAX};
    int y, c, oc, lat, exp_c;
    bit e, ox, to, exp_x;
    for (int i = 0; i < 48; i++) begin
      y = (i < 8) ? edge_y[i] : int'($urandom_range(255, 0));
      c = int'($urandom_range(255, 0));
      e = (i < 8) ? 1'b1 : ($urandom_range(3, 0) != 0);
      exp_c = ref_c(y, c, e, exp_x);
      do_pixel(y, c, e, oc, ox, lat, to);
      n_total++;
      if (to || oc != exp_c) $display("FAIL rand%0d_out_c y=%0d c=%0d en=%0d: got %0d want %0d", i, y, c, e, oc, exp_c);
      else n_pass++;
      n_total++;
      if (ox != exp_x) $display("FAIL rand%0d_xform y=%0d en=%0d: got %0d want %0d", i, y, e, ox, exp_x);
      else n_pass++;
      n_total++;
      if (lat != (exp_x ? XLAT : 1)) $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, exp_x ? XLAT : 1);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int exp_q[$];
    int c;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) begin
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b1 || out_xform !== 1'b0 || int'(out_c) != exp_q[0])
          $display("FAIL b2b%0d: got valid=%b c=%0d xf=%b want valid=1 c=%0d xf=0", i, out_valid, out_c, out_xform, exp_q[0]);
        else n_pass++;
        void'(exp_q.pop_front());
      end
      if (i < 10) begin
        c = int'($urandom_range(255, 0));
        if (i % 3 == 2) begin
          en = 1'b0; in_y = DW'($urandom_range(255, 0));
        end else begin
          en = 1'b1; in_y = DW'($urandom_range(K_H, K_L));
        end
        in_c = DW'(c); in_valid = 1'b1;
        exp_q.push_back(c);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0) $display("FAIL b2b_drain: got valid=%b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    in_y = 8'd200; in_c = 8'd180; en = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_y = 8'd150; in_c = 8'd77;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    n_total++; if (lat != XLAT) $display("FAIL bp_latency: got %0d want %0d", lat, XLAT); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (out_valid !== 1'b1 || out_c !== 8'd181 || out_xform !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL bp_hold%0d: got valid=%b c=%0d xf=%b rdy=%b want 1/181/1/0", i, out_valid, out_c, out_xform, in_ready);
      else n_pass++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", in_ready); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b1 || out_c !== 8'd77 || out_xform !== 1'b0)
      $display("FAIL bp_next_pixel: got valid=%b c=%0d xf=%b want 1/77/0", out_valid, out_c, out_xform);
    else n_pass++;
    in_valid = 1'b0;
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0) $display("FAIL bp_drain: got valid=%b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int seen, oc, lat;
    bit ox, to;
    @(negedge clk);
    in_y = 8'd100; in_c = 8'd150; en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", in_ready); else n_pass++;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_total++; if (seen != 0) $display("FAIL rstmid_ghost_output: got %0d outputs want 0", seen); else n_pass++;
    do_pixel(200, 180, 1'b1, oc, ox, lat, to);
    n_total++; if (to || oc != 181 || !ox) $display("FAIL rstmid_next: got c=%0d xf=%0d want 181/1", oc, ox); else n_pass++;
    n_total++; if (lat != XLAT) $display("FAIL rstmid_latency: got %0d want %0d", lat, XLAT); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; in_y = '0; in_c = '0; in_valid = 1'b0; out_ready = 1'b0;
    test_reset();
    test_vectors();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
